// File: rtl/pipe_ex_mem_skid.sv
// EX->MEM pipeline register with a one-entry skid buffer.
// The main entry drives the outputs directly; the skid entry absorbs one
// instruction when MEM stalls, so in_ready depends only on registered state.
// Ports:
//   clk, rst (async, active-high), flush (sync kill)
//   in_valid/in_ready + *_IN payload   : EX side handshake
//   out_valid/out_ready + *_OUT payload: MEM side handshake
//   STALL_CNT                          : saturating count of backpressure cycles
module pipe_ex_mem_skid #(
  parameter int WIDTH = 32,
  parameter int AW    = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             MEMWRITE_IN,
  input  logic             MEMTOREG_IN,
  input  logic             REGWRITE_IN,
  input  logic [WIDTH-1:0] RESULTOP_IN,
  input  logic [WIDTH-1:0] WRDATA_IN,
  input  logic [AW-1:0]    ARD_IN,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             MEMWRITE_OUT,
  output logic             MEMTOREG_OUT,
  output logic             REGWRITE_OUT,
  output logic [WIDTH-1:0] RESULTOP_OUT,
  output logic [WIDTH-1:0] WRDATA_OUT,
  output logic [AW-1:0]    ARD_OUT,
  output logic [CNT_W-1:0] STALL_CNT
);

  typedef struct packed {
    logic             mw;
    logic             mr;
    logic             rw;
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] wd;
    logic [AW-1:0]    ard;
  } pl_t;

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;

  state_t           state_q, state_d;
  pl_t              main_q, main_d, skid_q, skid_d, in_pl;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             push, pop;

  // Handshake flags come straight off the state register.
  assign out_valid = (state_q == ONE) || (state_q == FULL);
  assign in_ready  = (state_q == EMPTY) || (state_q == ONE);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  assign in_pl = '{mw: MEMWRITE_IN, mr: MEMTOREG_IN, rw: REGWRITE_IN,
                   res: RESULTOP_IN, wd: WRDATA_IN, ard: ARD_IN};

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = EMPTY;
      main_d  = '0;
      skid_d  = '0;
    end else begin
      case (state_q)
        EMPTY: if (push) begin
          main_d  = in_pl;
          state_d = ONE;
        end
        ONE: begin
          if (push && !pop) begin
            skid_d  = in_pl;
            state_d = FULL;
          end else if (pop && !push) begin
            state_d = EMPTY;
          end else if (push && pop) begin
            main_d  = in_pl;
          end
        end
        FULL: if (pop) begin
          main_d  = skid_q;
          state_d = ONE;
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // Backpressure counter saturates and survives flush.
  always_comb begin
    cnt_d = cnt_q;
    if (out_valid && !out_ready && !(&cnt_q))
      cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      cnt_q   <= cnt_d;
    end
  end

  // Control bits are gated so a bubble never writes; data shows main as-is.
  assign MEMWRITE_OUT = main_q.mw & out_valid;
  assign MEMTOREG_OUT = main_q.mr & out_valid;
  assign REGWRITE_OUT = main_q.rw & out_valid;
  assign RESULTOP_OUT = main_q.res;
  assign WRDATA_OUT   = main_q.wd;
  assign ARD_OUT      = main_q.ard;
  assign STALL_CNT    = cnt_q;

endmodule

// File: tb/tb_pipe_ex_mem_skid.sv
module tb_pipe_ex_mem_skid;

  localparam int WIDTH = 32;
  localparam int AW    = 5;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic             mw_i, mr_i, rw_i, mw_o, mr_o, rw_o;
  logic [WIDTH-1:0] res_i, wd_i, res_o, wd_o;
  logic [AW-1:0]    ard_i, ard_o;
  logic [CNT_W-1:0] cnt_o;

  always #5 clk = ~clk;

  pipe_ex_mem_skid #(.WIDTH(WIDTH), .AW(AW), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .MEMWRITE_IN(mw_i), .MEMTOREG_IN(mr_i), .REGWRITE_IN(rw_i),
    .RESULTOP_IN(res_i), .WRDATA_IN(wd_i), .ARD_IN(ard_i),
    .out_valid(out_valid), .out_ready(out_ready),
    .MEMWRITE_OUT(mw_o), .MEMTOREG_OUT(mr_o), .REGWRITE_OUT(rw_o),
    .RESULTOP_OUT(res_o), .WRDATA_OUT(wd_o), .ARD_OUT(ard_o),
    .STALL_CNT(cnt_o)
  );

  // Reference model: a 2-deep FIFO of instructions plus the last head seen
  // (the data outputs keep showing it after the FIFO drains).
  typedef struct {
    logic             mw, mr, rw;
    logic [WIDTH-1:0] res, wd;
    logic [AW-1:0]    ard;
  } ins_t;

  ins_t mq[$];
  ins_t last;
  int   mcnt;
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    last = '{default: '0};
    mcnt = 0;
  endtask

  task automatic check_model(input string tag);
    logic v;
    v = (mq.size() > 0);
    chk({tag, ".out_valid"}, 64'(out_valid), 64'(v));
    chk({tag, ".in_ready"},  64'(in_ready),  64'(mq.size() < 2));
    chk({tag, ".mw"},  64'(mw_o),  64'(last.mw & v));
    chk({tag, ".mr"},  64'(mr_o),  64'(last.mr & v));
    chk({tag, ".rw"},  64'(rw_o),  64'(last.rw & v));
    chk({tag, ".res"}, 64'(res_o), 64'(last.res));
    chk({tag, ".wd"},  64'(wd_o),  64'(last.wd));
    chk({tag, ".ard"}, 64'(ard_o), 64'(last.ard));
    chk({tag, ".cnt"}, 64'(cnt_o), 64'(mcnt));
  endtask

  task automatic drive(input logic v, input logic [WIDTH-1:0] r, input logic [WIDTH-1:0] w,
                       input logic [AW-1:0] a, input logic m1, input logic m2, input logic m3);
    in_valid = v; res_i = r; wd_i = w; ard_i = a; mw_i = m1; mr_i = m2; rw_i = m3;
  endtask

  // One clock: predict from the inputs currently driven, then compare at +1.
  task automatic cyc(input string tag);
    bit   do_push, do_pop, stalled;
    ins_t n;
    do_push = in_valid && (mq.size() < 2);
    do_pop  = (mq.size() > 0) && out_ready;
    stalled = (mq.size() > 0) && !out_ready;
    n = '{mw: mw_i, mr: mr_i, rw: rw_i, res: res_i, wd: wd_i, ard: ard_i};
    @(posedge clk);
    #1;
    if (stalled && mcnt < (1 << CNT_W) - 1) mcnt++;
    if (flush) begin
      mq.delete();
      last = '{default: '0};
    end else begin
      if (do_pop)  void'(mq.pop_front());
      if (do_push) mq.push_back(n);
      if (mq.size() > 0) last = mq[0];
    end
    check_model(tag);
  endtask

  task automatic do_reset();
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
    drive(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
    model_reset();
    #2;
    check_model("reset");
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    model_reset();
    do_reset();

    // Single push, then drain.
    out_ready = 1'b1;
    drive(1'b1, 32'hA5A5A5A5, 32'h55555555, 5'b10101, 1'b1, 1'b1, 1'b1);
    cyc("single");
    chk("single.res_const", 64'(res_o), 64'hA5A5A5A5);
    chk("single.v_const", 64'(out_valid), 64'd1);
    drive(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
    cyc("single_drain");
    chk("drain.rw_const", 64'(rw_o), 64'd0);

    // Back-to-back at full throughput.
    do_reset();
    out_ready = 1'b1;
    drive(1'b1, 32'hA5A5A5A5, 32'h1, 5'd1, 1'b0, 1'b1, 1'b1); cyc("b2b0");
    chk("b2b0.res_const", 64'(res_o), 64'hA5A5A5A5);
    drive(1'b1, 32'h12345678, 32'h2, 5'd2, 1'b1, 1'b0, 1'b1); cyc("b2b1");
    chk("b2b1.res_const", 64'(res_o), 64'h12345678);
    drive(1'b1, 32'h0000CAFE, 32'h3, 5'd3, 1'b1, 1'b1, 1'b0); cyc("b2b2");
    chk("b2b2.res_const", 64'(res_o), 64'h0000CAFE);
    chk("b2b2.rdy_const", 64'(in_ready), 64'd1);

    // Fill to FULL under backpressure, third push must be ignored.
    do_reset();
    drive(1'b1, 32'h11111111, 32'hA, 5'd4, 1'b1, 1'b0, 1'b1); cyc("bp0");
    drive(1'b1, 32'h22222222, 32'hB, 5'd5, 1'b0, 1'b1, 1'b1); cyc("bp1");
    chk("bp.full_rdy", 64'(in_ready), 64'd0);
    drive(1'b1, 32'h33333333, 32'hC, 5'd6, 1'b1, 1'b1, 1'b1); cyc("bp2");
    chk("bp.head_const", 64'(res_o), 64'h11111111);
    drive(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
    out_ready = 1'b1;
    cyc("bp3");
    chk("bp.second_const", 64'(res_o), 64'h22222222);
    cyc("bp4");
    chk("bp.empty_const", 64'(out_valid), 64'd0);
    chk("bp.cnt_const", 64'(cnt_o), 64'd2);

    // Flush from FULL with a push pending.
    do_reset();
    drive(1'b1, 32'hDEADBEEF, 32'h7, 5'd7, 1'b1, 1'b1, 1'b1); cyc("fl0");
    drive(1'b1, 32'hFEEDF00D, 32'h8, 5'd8, 1'b1, 1'b1, 1'b1); cyc("fl1");
    flush = 1'b1; out_ready = 1'b1;
    drive(1'b1, 32'h99999999, 32'h9, 5'd9, 1'b1, 1'b1, 1'b1); cyc("fl2");
    flush = 1'b0;
    chk("flush.res_const", 64'(res_o), 64'd0);
    chk("flush.cnt_const", 64'(cnt_o), 64'd1);

    // Stall counter saturation.
    do_reset();
    drive(1'b1, 32'h5A5A5A5A, 32'h1, 5'd1, 1'b1, 1'b0, 1'b0); cyc("sat_push");
    drive(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < (1 << CNT_W) + 3; i++) cyc("sat");
    chk("sat.cnt_const", 64'(cnt_o), 64'hF);

    // Asynchronous reset while FULL, between edges.
    do_reset();
    drive(1'b1, 32'hAAAA0001, 32'h1, 5'd1, 1'b1, 1'b1, 1'b1); cyc("ar0");
    drive(1'b1, 32'hAAAA0002, 32'h2, 5'd2, 1'b1, 1'b1, 1'b1); cyc("ar1");
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_model("async_rst");
    chk("async.res_const", 64'(res_o), 64'd0);
    #1 rst = 1'b0;
    out_ready = 1'b1;
    drive(1'b1, 32'hBBBB0003, 32'h3, 5'd3, 1'b0, 1'b1, 1'b0); cyc("ar_after");
    chk("async.after_const", 64'(res_o), 64'hBBBB0003);

    // Randomized bursts against the FIFO model.
    for (int b = 0; b < 3; b++) begin
      do_reset();
      for (int i = 0; i < 200; i++) begin
        flush     = ($urandom_range(0, 15) == 0);
        out_ready = ($urandom_range(0, 2) != 0) ^ (b == 1);
        drive($urandom_range(0, 3) != 0, $urandom, $urandom, AW'($urandom_range(0, 31)),
              1'($urandom), 1'($urandom), 1'($urandom));
        cyc("rand");
      end
      flush = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
